hnsn_stdp_layer: RTL and testbench

HNSN_STDP_LAYER -- requirements
Module: hnsn_stdp_layer

---
 rtl/hnsn_pkg.sv | 35 +++
 rtl/hnsn_lif_cell.sv | 53 +++++
 rtl/hnsn_stdp_layer.sv | 158 +++++++++++++++
 tb/tb_hnsn_stdp_layer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hnsn_pkg.sv
// Shared types and arithmetic helpers for the STDP spiking layer.
// Dopamine levels map to an LTP multiplier; all learning math uses a 32-bit signed accumulator.
package hnsn_pkg;

  typedef enum logic [1:0] {
    DA_NONE = 2'd0,
    DA_LOW  = 2'd1,
    DA_MID  = 2'd2,
    DA_HIGH = 2'd3
  } da_level_e;

  typedef logic signed [31:0] acc_t;

  function automatic logic [2:0] da_scale(input logic [1:0] da);
    case (da_level_e'(da))
      DA_LOW:  return 3'd1;
      DA_MID:  return 3'd2;
      DA_HIGH: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_u8(input acc_t x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return x[7:0];
  endfunction

  function automatic logic [7:0] clamp_w(input acc_t x, input logic [7:0] lo, input logic [7:0] hi);
    if (x < $signed({24'd0, lo})) return lo;
    if (x > $signed({24'd0, hi})) return hi;
    return x[7:0];
  endfunction

endpackage

// File: rtl/hnsn_lif_cell.sv
// One leaky integrate-and-fire neuron: combinational candidate potential plus
// registered membrane voltage and refractory counter.
module hnsn_lif_cell
  import hnsn_pkg::*;
#(
  parameter int         CUR_W     = 10,
  parameter logic [7:0] THRESHOLD = 8'd60,
  parameter logic [7:0] LEAK      = 8'd5,
  parameter logic [2:0] REFRACT   = 3'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CUR_W-1:0] i_cur,
  input  logic             i_fire,
  input  logic             i_clear,
  output logic [7:0]       o_v_cand,
  output logic             o_cand,
  output logic [7:0]       o_v
);

  logic [7:0] r_v;
  logic [2:0] r_refr;
  acc_t       w_sum;
  logic       w_refr_busy;

  always_comb begin
    w_sum       = $signed({24'd0, r_v}) + $signed(32'(i_cur)) - $signed({24'd0, LEAK});
    w_refr_busy = (r_refr != 3'd0);
    o_v_cand    = w_refr_busy ? 8'd0 : sat_u8(w_sum);
    o_cand      = !w_refr_busy && (o_v_cand >= THRESHOLD);
  end

  // Refractory takes priority: a busy neuron is never a candidate, so fire cannot coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 8'd0;
      r_refr <= 3'd0;
    end else if (w_refr_busy) begin
      r_refr <= r_refr - 3'd1;
      r_v    <= 8'd0;
    end else if (i_fire) begin
      r_v    <= 8'd0;
      r_refr <= REFRACT;
    end else if (i_clear) begin
      r_v    <= 8'd0;
    end else begin
      r_v    <= o_v_cand;
    end
  end

  assign o_v = r_v;

endmodule

// File: rtl/hnsn_stdp_layer.sv
// Fully connected layer of LIF neurons with optional winner-take-all and
// dopamine-modulated pair-based STDP on an NUM_IN x NUM_OUT weight array.
module hnsn_stdp_layer
  import hnsn_pkg::*;
#(
  parameter int         NUM_IN    = 4,
  parameter int         NUM_OUT   = 4,
  parameter logic [7:0] THRESHOLD = 8'd60,
  parameter logic [7:0] LEAK      = 8'd5,
  parameter logic [7:0] INIT_W    = 8'd20,
  parameter logic [7:0] W_MIN     = 8'd0,
  parameter logic [7:0] W_MAX     = 8'd200,
  parameter logic [7:0] LTP_STEP  = 8'd3,
  parameter logic [7:0] LTD_STEP  = 8'd1,
  parameter logic [3:0] TRACE_MAX = 4'd8,
  parameter logic [2:0] REFRACT   = 3'd2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          pre_spike,
  input  logic [1:0]                 dopamine,
  input  logic                       learn_en,
  input  logic                       wta_en,
  output logic [NUM_OUT-1:0]         post_spike,
  output logic [$clog2(NUM_OUT)-1:0] winner_idx,
  output logic                       winner_valid,
  output logic [NUM_OUT*8-1:0]       v_mem,
  input  logic [$clog2(NUM_IN)-1:0]  rd_row,
  input  logic [$clog2(NUM_OUT)-1:0] rd_col,
  output logic [7:0]                 rd_weight
);

  localparam int CUR_W = 8 + $clog2(NUM_IN);
  localparam int OW    = $clog2(NUM_OUT);

  logic [7:0]         r_w       [NUM_IN][NUM_OUT];
  logic [3:0]         r_pre_tr  [NUM_IN];
  logic [3:0]         r_post_tr [NUM_OUT];
  logic [NUM_OUT-1:0] r_post;
  logic [OW-1:0]      r_widx;
  logic               r_wvld;

  logic [CUR_W-1:0]   w_cur     [NUM_OUT];
  logic [7:0]         w_vcand   [NUM_OUT];
  logic [7:0]         w_v       [NUM_OUT];
  logic [NUM_OUT-1:0] w_cand;
  logic [NUM_OUT-1:0] w_fire;
  logic [NUM_OUT-1:0] w_clear;
  logic [OW-1:0]      w_idx_nxt;
  logic [7:0]         w_best;
  logic               w_found;
  logic               w_learn;
  acc_t               w_ltp;
  acc_t               w_dlt;
  logic [7:0]         w_wgt_nxt [NUM_IN][NUM_OUT];

  // Synaptic current: full-width sum of weights from every active input.
  always_comb begin
    for (int j = 0; j < NUM_OUT; j++) begin
      w_cur[j] = '0;
      for (int i = 0; i < NUM_IN; i++)
        if (pre_spike[i]) w_cur[j] = w_cur[j] + CUR_W'(r_w[i][j]);
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_cell
    hnsn_lif_cell #(
      .CUR_W    (CUR_W),
      .THRESHOLD(THRESHOLD),
      .LEAK     (LEAK),
      .REFRACT  (REFRACT)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_cur   (w_cur[j]),
      .i_fire  (w_fire[j]),
      .i_clear (w_clear[j]),
      .o_v_cand(w_vcand[j]),
      .o_cand  (w_cand[j]),
      .o_v     (w_v[j])
    );
    assign v_mem[8*j +: 8] = w_v[j];
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    w_fire  = '0;
    w_best  = '0;
    w_found = 1'b0;
    if (!wta_en) begin
      w_fire = w_cand;
    end else begin
      for (int j = 0; j < NUM_OUT; j++)
        if (w_cand[j] && (!w_found || (w_vcand[j] > w_best))) begin
          w_fire    = '0;
          w_fire[j] = 1'b1;
          w_best    = w_vcand[j];
          w_found   = 1'b1;
        end
    end
    w_clear   = (wta_en && (|w_fire)) ? ~w_fire : '0;
    w_idx_nxt = '0;
    for (int j = NUM_OUT - 1; j >= 0; j--)
      if (w_fire[j]) w_idx_nxt = OW'(j);
  end

  // Learning uses only pre-edge traces and the registered post spikes.
  always_comb begin
    w_learn = learn_en && (dopamine != 2'd0);
    w_ltp   = $signed(32'(da_scale(dopamine))) * $signed({24'd0, LTP_STEP});
    w_dlt   = '0;
    for (int i = 0; i < NUM_IN; i++)
      for (int j = 0; j < NUM_OUT; j++) begin
        w_dlt = '0;
        if (r_post[j] && (r_pre_tr[i] != 4'd0)) w_dlt = w_dlt + w_ltp;
        if (pre_spike[i] && (r_post_tr[j] != 4'd0)) w_dlt = w_dlt - $signed({24'd0, LTD_STEP});
        w_wgt_nxt[i][j] = clamp_w($signed({24'd0, r_w[i][j]}) + w_dlt, W_MIN, W_MAX);
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++)
        for (int j = 0; j < NUM_OUT; j++)
          r_w[i][j] <= INIT_W;
    end else if (w_learn) begin
      for (int i = 0; i < NUM_IN; i++)
        for (int j = 0; j < NUM_OUT; j++)
          r_w[i][j] <= w_wgt_nxt[i][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) r_pre_tr[i] <= 4'd0;
      for (int j = 0; j < NUM_OUT; j++) r_post_tr[j] <= 4'd0;
      r_post <= '0;
      r_widx <= '0;
      r_wvld <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)
        r_pre_tr[i] <= pre_spike[i] ? TRACE_MAX :
                       ((r_pre_tr[i] != 4'd0) ? r_pre_tr[i] - 4'd1 : 4'd0);
      for (int j = 0; j < NUM_OUT; j++)
        r_post_tr[j] <= w_fire[j] ? TRACE_MAX :
                        ((r_post_tr[j] != 4'd0) ? r_post_tr[j] - 4'd1 : 4'd0);
      r_post <= w_fire;
      r_widx <= w_idx_nxt;
      r_wvld <= |w_fire;
    end
  end

  assign post_spike   = r_post;
  assign winner_idx   = r_widx;
  assign winner_valid = r_wvld;
  assign rd_weight    = r_w[rd_row][rd_col];

endmodule

// File: tb/tb_hnsn_stdp_layer.sv
// Scoreboard bench for hnsn_stdp_layer: directed scenarios plus randomized traffic
// checked against a behavioural model of the layer.
module tb_hnsn_stdp_layer;

  localparam int NI = 4;
  localparam int NO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pre_spike = '0;
  logic [1:0]  dopamine = '0;
  logic        learn_en = 1'b0;
  logic        wta_en = 1'b0;
  logic [3:0]  post_spike;
  logic [1:0]  winner_idx;
  logic        winner_valid;
  logic [31:0] v_mem;
  logic [1:0]  rd_row = '0;
  logic [1:0]  rd_col = '0;
  logic [7:0]  rd_weight;

  int checks = 0;
  int failures = 0;

  always #20 clk = ~clk;

  hnsn_stdp_layer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_spike   (pre_spike),
    .dopamine    (dopamine),
    .learn_en    (learn_en),
    .wta_en      (wta_en),
    .post_spike  (post_spike),
    .winner_idx  (winner_idx),
    .winner_valid(winner_valid),
    .v_mem       (v_mem),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_weight   (rd_weight)
  );

  typedef struct {
    logic [3:0]  post;
    logic        vld;
    logic [1:0]  idx;
    logic [31:0] v;
    logic [7:0]  w;
  } exp_t;

  exp_t q[$];

  // Behavioural model state
  int mw[NI][NO];
  int mv[NO];
  int mref[NO];
  int mpre[NI];
  int mpost_tr[NO];
  int mpost[NO];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      mpre[i] = 0;
      for (int j = 0; j < NO; j++) mw[i][j] = 20;
    end
    for (int j = 0; j < NO; j++) begin
      mv[j] = 0; mref[j] = 0; mpost_tr[j] = 0; mpost[j] = 0;
    end
  endfunction

  function automatic void model_step(input logic [3:0] pre, input bit le, input int da, input bit wta);
    int cur;
    int vc[NO];
    int cand[NO];
    int fire[NO];
    int nw[NI][NO];
    int best, bi, any, scale, d;
    for (int j = 0; j < NO; j++) begin
      cur = 0;
      for (int i = 0; i < NI; i++) if (pre[i]) cur += mw[i][j];
      if (mref[j] > 0) begin
        vc[j] = 0; cand[j] = 0;
      end else begin
        vc[j] = mv[j] + cur - 5;
        if (vc[j] < 0) vc[j] = 0;
        if (vc[j] > 255) vc[j] = 255;
        cand[j] = (vc[j] >= 60) ? 1 : 0;
      end
    end
    best = -1; bi = -1;
    for (int j = 0; j < NO; j++) begin
      fire[j] = wta ? 0 : cand[j];
      if (wta && cand[j] == 1 && vc[j] > best) begin best = vc[j]; bi = j; end
    end
    if (bi >= 0) fire[bi] = 1;
    any = 0;
    for (int j = 0; j < NO; j++) if (fire[j] == 1) any = 1;
    scale = (da == 3) ? 4 : da;
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NO; j++) begin
        d = 0;
        if (le && da != 0) begin
          if (mpost[j] == 1 && mpre[i] > 0) d += 3 * scale;
          if (pre[i] && mpost_tr[j] > 0) d -= 1;
        end
        nw[i][j] = mw[i][j] + d;
        if (nw[i][j] < 0) nw[i][j] = 0;
        if (nw[i][j] > 200) nw[i][j] = 200;
      end
    for (int i = 0; i < NI; i++) begin
      mpre[i] = pre[i] ? 8 : ((mpre[i] > 0) ? mpre[i] - 1 : 0);
      for (int j = 0; j < NO; j++) mw[i][j] = nw[i][j];
    end
    for (int j = 0; j < NO; j++) begin
      mpost_tr[j] = (fire[j] == 1) ? 8 : ((mpost_tr[j] > 0) ? mpost_tr[j] - 1 : 0);
      if (mref[j] > 0) begin
        mref[j]--; mv[j] = 0;
      end else if (fire[j] == 1) begin
        mv[j] = 0; mref[j] = 2;
      end else if (wta && any == 1) begin
        mv[j] = 0;
      end else begin
        mv[j] = vc[j];
      end
      mpost[j] = fire[j];
    end
  endfunction

  task automatic cycle(input logic [3:0] pre, input bit le, input logic [1:0] da, input bit wta);
    exp_t e;
    @(negedge clk);
    pre_spike = pre;
    learn_en  = le;
    dopamine  = da;
    wta_en    = wta;
    rd_row    = 2'($urandom_range(0, 3));
    rd_col    = 2'($urandom_range(0, 3));
    model_step(pre, le, int'(da), wta);
    e.vld = 1'b0;
    e.idx = 2'd0;
    for (int j = NO - 1; j >= 0; j--) begin
      e.post[j] = (mpost[j] == 1);
      if (mpost[j] == 1) begin e.vld = 1'b1; e.idx = 2'(j); end
      e.v[8*j +: 8] = 8'(mv[j]);
    end
    e.w = 8'(mw[rd_row][rd_col]);
    q.push_back(e);
  endtask

  task automatic do_reset(input bit chk_async);
    @(negedge clk);
    rst_n = 1'b0;
    pre_spike = '0; learn_en = 1'b0; dopamine = '0; wta_en = 1'b0;
    if (chk_async)
      for (int r = 0; r < NI; r++)
        for (int c = 0; c < NO; c++) begin
          rd_row = 2'(r); rd_col = 2'(c);
          #1;
          chk("rd_weight_async_reset", 32'(rd_weight), 32'd20);
        end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_post_spike", 32'(post_spike), 32'd0);
    chk("reset_winner_valid", 32'(winner_valid), 32'd0);
    chk("reset_winner_idx", 32'(winner_idx), 32'd0);
    chk("reset_v_mem", v_mem, 32'd0);
  endtask

  task automatic check_w_rows(input int r0, input int r1, input int exp, input string name);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < NO; c++) begin
        rd_row = 2'(r); rd_col = 2'(c);
        #1;
        chk(name, 32'(rd_weight), 32'(exp));
      end
  endtask

  // Monitor: compares every registered output against the queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_post_spike", 32'(post_spike), 32'(e.post));
        chk("sb_winner_valid", 32'(winner_valid), 32'(e.vld));
        chk("sb_winner_idx", 32'(winner_idx), 32'(e.idx));
        chk("sb_v_mem", v_mem, e.v);
        chk("sb_rd_weight", 32'(rd_weight), 32'(e.w));
      end
    end
  end

  initial begin : watchdog
    #(40 * 6000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ev[6];
    int ep[6];
    int n;
    logic [7:0] b;
    ev = '{15, 30, 45, 0, 0, 0};
    ep = '{0, 0, 0, 15, 0, 0};
    model_reset();
    do_reset(1'b0);

    // Single input integrates to threshold, then two refractory cycles
    for (int k = 0; k < 6; k++) begin
      cycle(4'b0001, 1'b0, 2'd0, 1'b0);
      @(posedge clk); #2;
      b = 8'(ev[k]);
      chk("integrate_v_mem", v_mem, {4{b}});
      chk("integrate_post", 32'(post_spike), 32'(ep[k]));
    end

    do_reset(1'b0);
    cycle(4'b1111, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #2;
    chk("all_fire_post", 32'(post_spike), 32'hF);
    chk("all_fire_valid", 32'(winner_valid), 32'd1);
    chk("all_fire_idx", 32'(winner_idx), 32'd0);
    cycle(4'b0000, 1'b0, 2'd0, 1'b0);

    do_reset(1'b0);
    cycle(4'b1111, 1'b0, 2'd0, 1'b1);
    @(posedge clk); #2;
    chk("wta_post", 32'(post_spike), 32'h1);
    chk("wta_v_mem", v_mem, 32'd0);
    chk("wta_idx", 32'(winner_idx), 32'd0);

    do_reset(1'b0);
    cycle(4'b1111, 1'b1, 2'd2, 1'b0);
    cycle(4'b0000, 1'b1, 2'd2, 1'b0);
    @(posedge clk); #2;
    check_w_rows(0, 3, 26, "ltp_da2_weight");

    do_reset(1'b0);
    cycle(4'b1111, 1'b1, 2'd0, 1'b0);
    cycle(4'b0000, 1'b1, 2'd0, 1'b0);
    @(posedge clk); #2;
    check_w_rows(0, 3, 20, "da0_weight_hold");

    // Repeated causal pairings drive weights to the upper clamp
    do_reset(1'b0);
    repeat (25) begin
      cycle(4'b1111, 1'b1, 2'd3, 1'b0);
      cycle(4'b0000, 1'b1, 2'd3, 1'b0);
      cycle(4'b0000, 1'b1, 2'd3, 1'b0);
      cycle(4'b0000, 1'b1, 2'd3, 1'b0);
    end
    @(posedge clk); #2;
    check_w_rows(0, 3, 200, "ltp_sat_weight");

    // Input 0 drives firing; inputs 1..3 only spike afterwards and depress to zero
    do_reset(1'b0);
    repeat (14) begin
      n = 0;
      do begin
        cycle(4'b0001, 1'b0, 2'd0, 1'b0);
        n++;
      end while (mpost[0] == 0 && n < 12);
      chk("ltd_fire_reached", 32'(mpost[0]), 32'd1);
      cycle(4'b1110, 1'b1, 2'd1, 1'b0);
      cycle(4'b1110, 1'b1, 2'd1, 1'b0);
      repeat (8) cycle(4'b0000, 1'b0, 2'd0, 1'b0);
    end
    @(posedge clk); #2;
    check_w_rows(1, 3, 0, "ltd_floor_weight");
    check_w_rows(0, 0, 62, "ltd_driver_weight");

    do_reset(1'b1);

    for (int k = 0; k < 400; k++) begin
      if (k == 130 || k == 270) do_reset(1'b1);
      cycle(4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0),
            2'($urandom), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #5;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
